// File: rtl/led_scan_mux_pkg.sv
// Shared definitions for the LED scan multiplexer: scan phase encoding,
// active-low output levels and a width helper for the digit index.
package led_scan_mux_pkg;

  // Phase within a digit slot: dead-time first, then the digit is driven.
  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_e;

  // Anodes and decimal point are active-low on a common-anode display.
  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_OFF    = 1'b1;

  // Index width that stays legal for a single-digit display.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_scan_mux_if.sv
// Host-side bus of the LED scan multiplexer: word/dp load strobe in,
// scanned nibble, anodes, decimal point and frame tick out.
interface led_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] data_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic [3:0]            so_gma;
  logic [N_DIGITS-1:0]   an;
  logic                  dp;
  logic                  frame_tick;

  // Driver of the display word / consumer of the scan outputs.
  modport master (
    output data_in, dp_in, load,
    input  so_gma, an, dp, frame_tick
  );

  // The scanner itself.
  modport slave (
    input  data_in, dp_in, load,
    output so_gma, an, dp, frame_tick
  );
endinterface

// File: rtl/led_scan_mux_scan_tick_gen.sv
// Slot timing for the LED scanner: a per-slot cycle divider, the digit
// index and the BLANK/ON phase FSM. Exposes next-cycle values so the
// parent can register its outputs in step with the counters.
module scan_tick_gen
  import led_scan_mux_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int IDX_W        = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] idx_next_o,
  output logic             blank_next_o,
  output logic             slot_start_o,
  output logic             frame_wrap_o
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  // With no dead-time the slot opens directly in the ON phase.
  localparam scan_state_e SLOT_FIRST_STATE = (BLANK_CYCLES == 0) ? SCAN_ON : SCAN_BLANK;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic             wrap;

  assign wrap = (div_cnt_q == CNT_LAST);

  // Divider wraps at the end of each slot and advances the digit index.
  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Phase FSM: leave BLANK once the dead-time has elapsed, re-enter it on slot wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN_BLANK: if (div_cnt_d == CNT_BLANK) state_d = SCAN_ON;
      SCAN_ON:    if (wrap)                   state_d = SLOT_FIRST_STATE;
    endcase
  end

  // Counter and phase registers; reset restarts a full slot on digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      state_q   <= SLOT_FIRST_STATE;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
    end
  end

  assign idx_next_o   = idx_d;
  assign blank_next_o = (state_d == SCAN_BLANK);
  assign slot_start_o = wrap;
  assign frame_wrap_o = wrap && (idx_q == IDX_LAST);

endmodule

// File: rtl/led_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner. Holds a pending word
// from the load strobe and commits it to the display only at frame wrap,
// so a frame is never torn. Every output is a register.
// Optional build macro LEADING_ZERO_BLANK_EN: suppresses leading zero
// digits (digit 0 always shown) without altering scan timing.
module led_scan_mux
  import led_scan_mux_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic          clk,
  input  logic          reset,
  led_scan_mux_if.slave bus
);

  localparam int IDX_W = idx_width(N_DIGITS);

  logic [IDX_W-1:0] idx_next;
  logic             blank_next;
  logic             slot_start;
  logic             frame_wrap;

  scan_tick_gen #(
    .N_DIGITS     (N_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_tick (
    .clk          (clk),
    .reset        (reset),
    .idx_next_o   (idx_next),
    .blank_next_o (blank_next),
    .slot_start_o (slot_start),
    .frame_wrap_o (frame_wrap)
  );

  logic [N_DIGITS-1:0][3:0] disp_q, disp_d;
  logic [N_DIGITS-1:0][3:0] pend_q, pend_d;
  logic [N_DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [3:0]               so_gma_q, so_gma_d;
  logic [N_DIGITS-1:0]      an_q, an_d;
  logic                     dp_out_q, dp_out_d;
  logic                     frame_tick_q;
  logic [N_DIGITS-1:0]      lz_mask;

  // Pending/display update: a load on the wrap edge bypasses pending straight to the display.
  always_comb begin
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    if (bus.load) begin
      pend_d       = bus.data_in;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end
    if (frame_wrap) begin
      pend_valid_d = 1'b0;
      if (bus.load) begin
        disp_d    = bus.data_in;
        disp_dp_d = bus.dp_in;
      end else if (pend_valid_q) begin
        disp_d    = pend_q;
        disp_dp_d = pend_dp_q;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is a leading zero when it and every higher digit is 0 with no dp lit.
  logic [4*N_DIGITS-1:0] disp_flat;
  assign disp_flat  = disp_d;
  assign lz_mask[0] = 1'b0;
  for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_lzb
    assign lz_mask[gi] = (disp_flat[4*N_DIGITS-1:4*gi] == '0) &&
                         (disp_dp_d[N_DIGITS-1:gi] == '0);
  end
`else
  assign lz_mask = '0;
`endif

  // Output next-state, aligned with the counters' next values so outputs track the slot exactly.
  always_comb begin
    an_d     = {N_DIGITS{ANODE_OFF}};
    dp_out_d = DP_OFF;
    so_gma_d = so_gma_q;
    if (slot_start) begin
      so_gma_d = disp_d[idx_next];
    end
    if (!blank_next && !lz_mask[idx_next]) begin
      an_d[idx_next] = ~ANODE_OFF;
      dp_out_d       = ~disp_dp_d[idx_next];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      so_gma_q     <= '0;
      an_q         <= {N_DIGITS{ANODE_OFF}};
      dp_out_q     <= DP_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      so_gma_q     <= so_gma_d;
      an_q         <= an_d;
      dp_out_q     <= dp_out_d;
      frame_tick_q <= frame_wrap;
    end
  end

  assign bus.so_gma     = so_gma_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench for led_scan_mux (4 digits, 8-cycle slots, 2-cycle
// dead-time). Stimulus pushes per-cycle expected outputs tagged with the
// cycle number; a monitor pops and compares on the falling edge.
module tb_led_scan_mux;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  led_scan_mux_if #(.N_DIGITS(N)) bus ();

  led_scan_mux #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] so;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic logic lead_zero(input logic [15:0] word, input logic [3:0] dpv, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    return (k > 0) && ((word >> (4 * k)) == 16'h0) && ((dpv >> k) == 4'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_reset(input int cy);
    exp_t e;
    e.cyc = cy; e.an = 4'hF; e.so = 4'h0; e.dp = 1'b1; e.ft = 1'b0;
    exp_q.push_back(e);
  endtask

  // One frame as seen on the pins: per slot BC blank cycles, then the digit lit.
  task automatic push_frame(input int start, input logic [15:0] word, input logic [3:0] dpv,
                            input logic tick, input int last);
    exp_t       e;
    logic [3:0] one;
    logic       off;
    one = 4'b0001;
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < RD; c++) begin
        if (start + RD * k + c <= last) begin
          off   = (c < BC) || lead_zero(word, dpv, k);
          e.cyc = start + RD * k + c;
          e.so  = word[4*k +: 4];
          e.an  = off ? 4'hF : ~(one << k);
          e.dp  = off ? 1'b1 : ~dpv[k];
          e.ft  = (k == 0 && c == 0) ? tick : 1'b0;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic do_load(input logic [15:0] word, input logic [3:0] dpv, input int at);
    wait_until(at);
    bus.data_in = word;
    bus.dp_in   = dpv;
    bus.load    = 1'b1;
    wait_until(at + 1);
    bus.load    = 1'b0;
  endtask

  // Monitor: compare the DUT pins against the entry scheduled for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_check cyc=%0d never compared", e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.an !== e.an || bus.so_gma !== e.so || bus.dp !== e.dp || bus.frame_tick !== e.ft) begin
          n_fail++;
          $display("FAIL scan cyc=%0d got an=%b so=%h dp=%b ft=%b expected an=%b so=%h dp=%b ft=%b",
                   cyc, bus.an, bus.so_gma, bus.dp, bus.frame_tick, e.an, e.so, e.dp, e.ft);
        end else begin
          $display("ok cyc=%0d an=%b so=%h dp=%b ft=%b", cyc, bus.an, bus.so_gma, bus.dp, bus.frame_tick);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bus.data_in = '0;
    bus.dp_in   = '0;
    bus.load    = 1'b0;

    // Reset held 3 cycles, then free run with an all-zero display.
    push_reset(1);
    push_reset(2);
    push_frame(3,  16'h0000, 4'b0000, 1'b0, 9999);
    push_frame(35, 16'h0000, 4'b0000, 1'b1, 9999);
    push_frame(67, 16'h0000, 4'b0000, 1'b1, 9999);
    wait_until(3);
    reset = 1'b0;

    // Mid-frame load while digit 2 is scanned: visible from the next frame only.
    wait_until(84);
    push_frame(99, 16'h1234, 4'b0010, 1'b1, 9999);
    do_load(16'h1234, 4'b0010, 84);

    // Pending value that the coincident load below must override.
    do_load(16'hFFFF, 4'b1111, 120);

    // Load on the frame-wrap edge goes straight to the display.
    wait_until(130);
    push_frame(131, 16'hABCD, 4'b0000, 1'b1, 9999);
    do_load(16'hABCD, 4'b0000, 130);

    // Follow-up load two cycles later waits for the next frame.
    wait_until(132);
    push_frame(163, 16'h5555, 4'b1000, 1'b1, 9999);
    push_frame(195, 16'h5555, 4'b1000, 1'b1, 214);
    do_load(16'h5555, 4'b1000, 132);

    // Reset pulse during digit 2 ON phase: full restart with a cleared display.
    wait_until(214);
    push_frame(215, 16'h0000, 4'b0000, 1'b0, 9999);
    reset = 1'b1;
    wait_until(215);
    reset = 1'b0;

    // Leading-zero pattern.
    wait_until(229);
    push_frame(247, 16'h0070, 4'b0000, 1'b1, 9999);
    do_load(16'h0070, 4'b0000, 229);

    wait_until(285);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog got timeout at cyc=%0d expected finish by cyc 285", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
